// File: rtl/aqp_sync_fifo.sv
// aqp_sync_fifo -- parametrised single-clock FIFO with optional first-word-fall-through.
//
// Ports:
//   clk           system clock, all logic on rising edge
//   reset_n       synchronous active-low reset (priority over everything)
//   flush         synchronous clear of contents and sticky error flags
//   wrdata/wr_en  write port; accepted when !full
//   rddata/rd_en  read port; accepted when !empty
//                 FWFT=0: rddata registered, valid the cycle after an accepted read
//                 FWFT=1: rddata shows the head word whenever !empty
//   empty, full, almost_full, almost_empty, count  occupancy status (registered state only)
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module aqp_sync_fifo #(
  parameter int WIDTH        = 9,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_LEVEL  = 8,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wrdata,
  input  logic                  wr_en,
  output logic [WIDTH-1:0]      rddata,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AE_LVL   = PW'(AEMPTY_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  logic [PW-1:0]    wrptr, rdptr;
  logic             wr_acc, rd_acc;

  // Status comes only from the registered pointers, never from wr_en/rd_en.
  assign count        = wrptr - rdptr;
  assign empty        = (wrptr == rdptr);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // Both requests are judged against pre-edge flags, so a full FIFO still
  // pops on rd_en and an empty FIFO still pushes on wr_en.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrptr     <= '0;
      rdptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // Requests during flush are ignored and raise no flags.
      wrptr     <= '0;
      rdptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)          wrptr     <= wrptr + PW'(1);
      if (rd_acc)          rdptr     <= rdptr + PW'(1);
      if (wr_en && full)   overflow  <= 1'b1;
      if (rd_en && empty)  underflow <= 1'b1;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && wr_acc)
      mem[wrptr[DEPTH_LOG2-1:0]] <= wrdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word straight from memory; meaningless while empty.
      assign rddata = mem[rdptr[DEPTH_LOG2-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] rddata_q;
      always_ff @(posedge clk) begin
        if (!reset_n)
          rddata_q <= '0;
        else if (!flush && rd_acc)
          rddata_q <= mem[rdptr[DEPTH_LOG2-1:0]];
      end
      assign rddata = rddata_q;
    end
  endgenerate

endmodule
